// File: rtl/clock_div_pkg.sv
// ---------------------------------------------------------------------------
// clock_div_pkg
//   Shared constants and helpers for the multi-channel clock divider.
//   MODE_TOGGLE / MODE_PULSE : encodings of the per-channel mode input
//   MIN_DIV                  : smallest ratio a channel will actually run
//   clamp_ratio()            : clamps a requested ratio to >= MIN_DIV and
//                              flags when clamping happened
// ---------------------------------------------------------------------------
package clock_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;
  localparam int   MIN_DIV     = 2;

  // Ratio is carried at 32 bits so one helper serves any channel width up
  // to 32; callers zero-extend their ratio in and truncate the result back.
  typedef struct packed {
    logic        err;
    logic [31:0] ratio;
  } clamp_t;

  function automatic clamp_t clamp_ratio(input logic [31:0] r);
    clamp_t res;
    if (r < 32'(MIN_DIV)) begin
      res.err   = 1'b1;
      res.ratio = 32'(MIN_DIV);
    end else begin
      res.err   = 1'b0;
      res.ratio = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// ---------------------------------------------------------------------------
// clock_divider_ch
//   One divider channel: counter, active-ratio register and registered
//   outputs.
//   clock_in   : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : run enable; low holds the channel idle and reloads the ratio
//   mode       : MODE_TOGGLE (~50% duty) or MODE_PULSE (1 cycle per period)
//   div_ratio  : requested ratio, sampled only at load points
//   sync_in    : restart strobe, zeroes the counter and reloads the ratio
//   clock_out  : divided clock / pulse
//   tick_out   : strobe on the last count of each period
//   ratio_err  : active ratio is a clamped value
// ---------------------------------------------------------------------------
module clock_divider_ch
  import clock_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic             sync_in,
  output logic             clock_out,
  output logic             tick_out,
  output logic             ratio_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ra_q, ra_d;
  logic             err_q, err_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] hi;
  logic             wrap;
  logic             load;
  clamp_t           clamped;

  // High phase length derives from the active ratio so a pending ratio
  // change cannot distort the period already in progress.
  assign hi      = (ra_q >> 1) + CNT_W'(ra_q[0]);
  assign wrap    = (cnt_q == ra_q - CNT_W'(1));
  assign clamped = clamp_ratio(32'(div_ratio));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    cnt_d  = cnt_q;
    ra_d   = ra_q;
    err_d  = err_q;
    clk_d  = clk_q;
    tick_d = tick_q;
    load   = 1'b0;

    // Priority: disable beats sync, sync beats wrap.
    if (!enable) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      load   = 1'b1;
    end else if (sync_in) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      load   = 1'b1;
    end else begin
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      tick_d = wrap;
      clk_d  = (mode == MODE_PULSE) ? (cnt_q == '0) : (cnt_q < hi);
      load   = wrap;
    end

    if (load) begin
      ra_d  = CNT_W'(clamped.ratio);
      err_d = clamped.err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      ra_q   <= CNT_W'(DEFAULT_DIV);
      err_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ra_q   <= ra_d;
      err_q  <= err_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clock_out = clk_q;
  assign tick_out  = tick_q;
  assign ratio_err = err_q;

endmodule

// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//   NUM_CH independent programmable clock dividers sharing one system clock
//   and a common phase-alignment strobe.
//   clock_in   : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : per-channel run enable
//   mode       : per-channel mode, 0 = toggle, 1 = pulse
//   div_ratio  : per-channel ratio, channel i at [i*CNT_W +: CNT_W]
//   sync_in    : 1-cycle strobe restarting all enabled channels in phase
//   clock_out  : per-channel divided clock / pulse
//   tick_out   : per-channel last-count strobe
//   ratio_err  : per-channel clamped-ratio flag
// ---------------------------------------------------------------------------
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] div_ratio,
  input  logic                    sync_in,
  output logic [NUM_CH-1:0]       clock_out,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH-1:0]       ratio_err
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .enable    (enable[i]),
      .mode      (mode[i]),
      .div_ratio (div_ratio[i*CNT_W +: CNT_W]),
      .sync_in   (sync_in),
      .clock_out (clock_out[i]),
      .tick_out  (tick_out[i]),
      .ratio_err (ratio_err[i])
    );
  end

endmodule
